// File: rtl/adbg_halt_pkg.sv
// Shared types for the per-core debug halt controller.
// State and cause encodings are visible on the bench side, so they stay stable.
package adbg_halt_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2,
    RESUME = 2'd3
  } halt_state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'b00,
    CAUSE_HOST = 2'b01,
    CAUSE_HWBP = 2'b10,
    CAUSE_STEP = 2'b11
  } halt_cause_t;

  localparam int unsigned CNT_W = 8;

endpackage

// File: rtl/adbg_core_halt_fsm.sv
// Single-core halt FSM: freezes the pipeline on host stall, hardware breakpoint
// or single-step, waits for drain (with timeout), and resumes on stall release.
module adbg_core_halt_fsm
  import adbg_halt_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DRAIN_TO = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              step_en_i,
  input  logic              hwbp_en_i,
  input  logic [ADDR_W-1:0] hwbp_addr_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              retire_i,
  input  logic              idle_i,
  output logic              hold_o,
  output logic              bp_o,
  output logic              halted_o,
  output logic [1:0]        cause_o,
  output logic              drain_err_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_TO - 1);

  halt_state_t      state_q;
  halt_cause_t      cause_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             step_pend_q;
  logic             stall_seen_q;
  logic             hold_q;
  logic             bp_q;
  logic             halted_q;
  logic             drain_err_q;
  logic             bp_hit;
  logic             step_hit;

  assign bp_hit   = retire_i & hwbp_en_i & (pc_i == hwbp_addr_i);
  assign step_hit = retire_i & step_pend_q;
  assign cnt_d    = cnt_q + CNT_W'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= RUN;
      cause_q      <= CAUSE_NONE;
      cnt_q        <= '0;
      step_pend_q  <= 1'b0;
      stall_seen_q <= 1'b0;
      hold_q       <= 1'b0;
      bp_q         <= 1'b0;
      halted_q     <= 1'b0;
      drain_err_q  <= 1'b0;
    end else begin
      bp_q <= 1'b0;
      case (state_q)
        RUN: begin
          if (bp_hit || step_hit || stall_i) begin
            state_q     <= DRAIN;
            hold_q      <= 1'b1;
            cnt_q       <= '0;
            drain_err_q <= 1'b0;
            bp_q        <= bp_hit | step_hit;
            if (bp_hit || step_hit) step_pend_q <= 1'b0;
            if (bp_hit)        cause_q <= CAUSE_HWBP;
            else if (step_hit) cause_q <= CAUSE_STEP;
            else               cause_q <= CAUSE_HOST;
          end
        end
        DRAIN: begin
          cnt_q <= cnt_d;
          // Idle wins over a timeout that lands on the same cycle.
          if (idle_i || (cnt_q == CNT_LAST)) begin
            state_q      <= HALTED;
            halted_q     <= 1'b1;
            stall_seen_q <= (cause_q == CAUSE_HOST);
            if (!idle_i) drain_err_q <= 1'b1;
          end
        end
        HALTED: begin
          // A breakpoint halt must see the host stall rise before it may resume.
          if (stall_seen_q && !stall_i) begin
            state_q      <= RESUME;
            hold_q       <= 1'b0;
            halted_q     <= 1'b0;
            cause_q      <= CAUSE_NONE;
            step_pend_q  <= step_en_i;
            stall_seen_q <= 1'b0;
            cnt_q        <= '0;
          end else if (stall_i) begin
            stall_seen_q <= 1'b1;
          end
        end
        RESUME: begin
          state_q <= RUN;
        end
        default: begin
          state_q <= RUN;
        end
      endcase
    end
  end

  assign hold_o      = hold_q;
  assign bp_o        = bp_q;
  assign halted_o    = halted_q;
  assign cause_o     = cause_q;
  assign drain_err_o = drain_err_q;

endmodule

// File: rtl/adbg_core_halt_ctrl.sv
// CPU-side responder to the debug unit stall/breakpoint interface.
// One independent halt FSM per core; this level only slices the vectors.
module adbg_core_halt_ctrl
  import adbg_halt_pkg::*;
#(
  parameter int unsigned NB_CORES = 4,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DRAIN_TO = 255
) (
  input  logic                       cpu_clk_i,
  input  logic                       cpu_rst_i,
  input  logic [NB_CORES-1:0]        cpu_stall_i,
  input  logic [NB_CORES-1:0]        step_en_i,
  input  logic [NB_CORES-1:0]        hwbp_en_i,
  input  logic [NB_CORES*ADDR_W-1:0] hwbp_addr_i,
  input  logic [NB_CORES*ADDR_W-1:0] core_pc_i,
  input  logic [NB_CORES-1:0]        core_retire_i,
  input  logic [NB_CORES-1:0]        core_idle_i,
  output logic [NB_CORES-1:0]        core_hold_o,
  output logic [NB_CORES-1:0]        bp_o,
  output logic [NB_CORES-1:0]        halted_o,
  output logic [NB_CORES*2-1:0]      halt_cause_o,
  output logic [NB_CORES-1:0]        drain_err_o
);

  for (genvar i = 0; i < NB_CORES; i++) begin : g_core
    adbg_core_halt_fsm #(
      .ADDR_W  (ADDR_W),
      .DRAIN_TO(DRAIN_TO)
    ) u_fsm (
      .clk_i      (cpu_clk_i),
      .rst_i      (cpu_rst_i),
      .stall_i    (cpu_stall_i[i]),
      .step_en_i  (step_en_i[i]),
      .hwbp_en_i  (hwbp_en_i[i]),
      .hwbp_addr_i(hwbp_addr_i[i*ADDR_W +: ADDR_W]),
      .pc_i       (core_pc_i[i*ADDR_W +: ADDR_W]),
      .retire_i   (core_retire_i[i]),
      .idle_i     (core_idle_i[i]),
      .hold_o     (core_hold_o[i]),
      .bp_o       (bp_o[i]),
      .halted_o   (halted_o[i]),
      .cause_o    (halt_cause_o[i*2 +: 2]),
      .drain_err_o(drain_err_o[i])
    );
  end

endmodule

// File: tb/tb_adbg_core_halt_ctrl.sv
// Directed bench for adbg_core_halt_ctrl with two cores and a short drain timeout.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_adbg_core_halt_ctrl;

  localparam int NB  = 2;
  localparam int AW  = 32;
  localparam int DTO = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NB-1:0]     stall, step_en, hwbp_en, retire, idle;
  logic [NB*AW-1:0]  hwbp_addr, pc;
  logic [NB-1:0]     hold, bp, halted, derr;
  logic [2*NB-1:0]   cause;
  int                err_cnt = 0;
  int                chk_cnt = 0;

  always #5 clk = ~clk;

  adbg_core_halt_ctrl #(.NB_CORES(NB), .ADDR_W(AW), .DRAIN_TO(DTO)) u_dut (
    .cpu_clk_i    (clk),
    .cpu_rst_i    (rst),
    .cpu_stall_i  (stall),
    .step_en_i    (step_en),
    .hwbp_en_i    (hwbp_en),
    .hwbp_addr_i  (hwbp_addr),
    .core_pc_i    (pc),
    .core_retire_i(retire),
    .core_idle_i  (idle),
    .core_hold_o  (hold),
    .bp_o         (bp),
    .halted_o     (halted),
    .halt_cause_o (cause),
    .drain_err_o  (derr)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick();
    chk_cnt++; if (hold !== 2'b00) begin err_cnt++; $display("FAIL rst_hold: got %b want 00", hold); end
    chk_cnt++; if (bp !== 2'b00) begin err_cnt++; $display("FAIL rst_bp: got %b want 00", bp); end
    chk_cnt++; if (halted !== 2'b00) begin err_cnt++; $display("FAIL rst_halted: got %b want 00", halted); end
    chk_cnt++; if (cause !== 4'b0000) begin err_cnt++; $display("FAIL rst_cause: got %b want 0000", cause); end
    chk_cnt++; if (derr !== 2'b00) begin err_cnt++; $display("FAIL rst_derr: got %b want 00", derr); end
    rst = 1'b0; tick();
  endtask

  task automatic test_host_halt();
    stall = 2'b01; tick();
    chk_cnt++; if (hold !== 2'b01) begin err_cnt++; $display("FAIL host_hold: got %b want 01", hold); end
    chk_cnt++; if (bp !== 2'b00) begin err_cnt++; $display("FAIL host_bp: got %b want 00", bp); end
    chk_cnt++; if (cause !== 4'b0001) begin err_cnt++; $display("FAIL host_cause: got %b want 0001", cause); end
    chk_cnt++; if (halted !== 2'b00) begin err_cnt++; $display("FAIL host_drain_halted: got %b want 00", halted); end
    tick();
    chk_cnt++; if (halted !== 2'b01) begin err_cnt++; $display("FAIL host_halted: got %b want 01", halted); end
    chk_cnt++; if (bp !== 2'b00) begin err_cnt++; $display("FAIL host_bp2: got %b want 00", bp); end
    tick();
    chk_cnt++; if (halted !== 2'b01) begin err_cnt++; $display("FAIL host_stay: got %b want 01", halted); end
    stall = 2'b00; tick();
    chk_cnt++; if (hold !== 2'b00) begin err_cnt++; $display("FAIL host_resume_hold: got %b want 00", hold); end
    chk_cnt++; if (halted !== 2'b00) begin err_cnt++; $display("FAIL host_resume_halted: got %b want 00", halted); end
    chk_cnt++; if (cause !== 4'b0000) begin err_cnt++; $display("FAIL host_resume_cause: got %b want 0000", cause); end
    tick();
    chk_cnt++; if (hold !== 2'b00) begin err_cnt++; $display("FAIL host_run_hold: got %b want 00", hold); end
  endtask

  task automatic test_hwbp();
    hwbp_en = 2'b01; hwbp_addr[31:0] = 32'h0000_1040;
    pc[31:0] = 32'h0000_1044; retire = 2'b01; tick(); retire = 2'b00;
    chk_cnt++; if (bp !== 2'b00) begin err_cnt++; $display("FAIL bp_miss_bp: got %b want 00", bp); end
    chk_cnt++; if (hold !== 2'b00) begin err_cnt++; $display("FAIL bp_miss_hold: got %b want 00", hold); end
    pc[31:0] = 32'h0000_1040; retire = 2'b01; tick(); retire = 2'b00;
    chk_cnt++; if (bp !== 2'b01) begin err_cnt++; $display("FAIL bp_pulse: got %b want 01", bp); end
    chk_cnt++; if (hold !== 2'b01) begin err_cnt++; $display("FAIL bp_hold: got %b want 01", hold); end
    chk_cnt++; if (cause !== 4'b0010) begin err_cnt++; $display("FAIL bp_cause: got %b want 0010", cause); end
    tick();
    chk_cnt++; if (bp !== 2'b00) begin err_cnt++; $display("FAIL bp_pulse_end: got %b want 00", bp); end
    chk_cnt++; if (halted !== 2'b01) begin err_cnt++; $display("FAIL bp_halted: got %b want 01", halted); end
    repeat (3) tick();
    chk_cnt++; if (halted !== 2'b01) begin err_cnt++; $display("FAIL bp_wait_stall: got %b want 01", halted); end
    stall = 2'b01; tick();
    chk_cnt++; if (halted !== 2'b01) begin err_cnt++; $display("FAIL bp_stall_high: got %b want 01", halted); end
    stall = 2'b00; tick();
    chk_cnt++; if (halted !== 2'b00) begin err_cnt++; $display("FAIL bp_resume: got %b want 00", halted); end
    chk_cnt++; if (cause !== 4'b0000) begin err_cnt++; $display("FAIL bp_resume_cause: got %b want 0000", cause); end
    tick(); hwbp_en = 2'b00;
  endtask

  task automatic test_step();
    stall = 2'b01; tick(); tick();
    step_en = 2'b01; stall = 2'b00; tick();
    chk_cnt++; if (halted !== 2'b00) begin err_cnt++; $display("FAIL step_resume: got %b want 00", halted); end
    tick(); step_en = 2'b00;
    pc[31:0] = 32'h0000_1044; retire = 2'b01; tick(); retire = 2'b00;
    chk_cnt++; if (bp !== 2'b01) begin err_cnt++; $display("FAIL step_bp: got %b want 01", bp); end
    chk_cnt++; if (cause !== 4'b0011) begin err_cnt++; $display("FAIL step_cause: got %b want 0011", cause); end
    chk_cnt++; if (hold !== 2'b01) begin err_cnt++; $display("FAIL step_hold: got %b want 01", hold); end
    tick();
    chk_cnt++; if (halted !== 2'b01) begin err_cnt++; $display("FAIL step_halted: got %b want 01", halted); end
    stall = 2'b01; tick(); stall = 2'b00; tick(); tick();
    pc[31:0] = 32'h0000_1048; retire = 2'b01; tick(); retire = 2'b00;
    chk_cnt++; if (bp !== 2'b00) begin err_cnt++; $display("FAIL step_off_bp: got %b want 00", bp); end
    chk_cnt++; if (hold !== 2'b00) begin err_cnt++; $display("FAIL step_off_hold: got %b want 00", hold); end
  endtask

  task automatic test_priority();
    stall = 2'b01; tick(); tick();
    step_en = 2'b01; stall = 2'b00; tick(); tick(); step_en = 2'b00;
    hwbp_en = 2'b01; hwbp_addr[31:0] = 32'h0000_2000; pc[31:0] = 32'h0000_2000;
    retire = 2'b01; stall = 2'b01; tick(); retire = 2'b00;
    chk_cnt++; if (cause !== 4'b0010) begin err_cnt++; $display("FAIL prio_cause: got %b want 0010", cause); end
    chk_cnt++; if (bp !== 2'b01) begin err_cnt++; $display("FAIL prio_bp: got %b want 01", bp); end
    tick();
    chk_cnt++; if (bp !== 2'b00) begin err_cnt++; $display("FAIL prio_single_pulse: got %b want 00", bp); end
    chk_cnt++; if (halted !== 2'b01) begin err_cnt++; $display("FAIL prio_halted: got %b want 01", halted); end
    tick(); stall = 2'b00; tick(); tick();
    hwbp_en = 2'b00; pc[31:0] = 32'h0000_2004; retire = 2'b01; tick(); retire = 2'b00;
    chk_cnt++; if (hold !== 2'b00) begin err_cnt++; $display("FAIL prio_after_hold: got %b want 00", hold); end
  endtask

  task automatic test_drain_timeout();
    idle = 2'b10; stall = 2'b01; tick();
    chk_cnt++; if (hold !== 2'b01) begin err_cnt++; $display("FAIL to_hold: got %b want 01", hold); end
    chk_cnt++; if (derr !== 2'b00) begin err_cnt++; $display("FAIL to_derr_clr: got %b want 00", derr); end
    tick();
    hwbp_en = 2'b01; pc[31:0] = 32'h0000_2000; retire = 2'b01; tick(); retire = 2'b00; hwbp_en = 2'b00;
    chk_cnt++; if (bp !== 2'b00) begin err_cnt++; $display("FAIL to_retire_bp: got %b want 00", bp); end
    chk_cnt++; if (cause !== 4'b0001) begin err_cnt++; $display("FAIL to_retire_cause: got %b want 0001", cause); end
    tick();
    chk_cnt++; if (halted !== 2'b00) begin err_cnt++; $display("FAIL to_early: got %b want 00", halted); end
    tick();
    chk_cnt++; if (halted !== 2'b01) begin err_cnt++; $display("FAIL to_halted: got %b want 01", halted); end
    chk_cnt++; if (derr !== 2'b01) begin err_cnt++; $display("FAIL to_derr: got %b want 01", derr); end
    stall = 2'b00; tick();
    chk_cnt++; if (derr !== 2'b01) begin err_cnt++; $display("FAIL to_derr_resume: got %b want 01", derr); end
    tick();
    chk_cnt++; if (derr !== 2'b01) begin err_cnt++; $display("FAIL to_derr_run: got %b want 01", derr); end
    idle = 2'b11; stall = 2'b01; tick();
    chk_cnt++; if (derr !== 2'b00) begin err_cnt++; $display("FAIL to_derr_reentry: got %b want 00", derr); end
    tick(); stall = 2'b00; tick(); tick();
  endtask

  task automatic test_back_to_back();
    stall = 2'b10; tick();
    chk_cnt++; if (hold !== 2'b10) begin err_cnt++; $display("FAIL c1_hold: got %b want 10", hold); end
    chk_cnt++; if (cause !== 4'b0100) begin err_cnt++; $display("FAIL c1_cause: got %b want 0100", cause); end
    tick();
    chk_cnt++; if (halted !== 2'b10) begin err_cnt++; $display("FAIL c1_halted: got %b want 10", halted); end
    stall = 2'b00; tick(); tick();
    chk_cnt++; if (hold !== 2'b00) begin err_cnt++; $display("FAIL c1_run: got %b want 00", hold); end
  endtask

  task automatic test_reset_mid();
    stall = 2'b01; tick(); tick();
    chk_cnt++; if (halted !== 2'b01) begin err_cnt++; $display("FAIL rm_halted: got %b want 01", halted); end
    rst = 1'b1; tick();
    chk_cnt++; if (hold !== 2'b00) begin err_cnt++; $display("FAIL rm_hold: got %b want 00", hold); end
    chk_cnt++; if (halted !== 2'b00) begin err_cnt++; $display("FAIL rm_halted0: got %b want 00", halted); end
    chk_cnt++; if (cause !== 4'b0000) begin err_cnt++; $display("FAIL rm_cause: got %b want 0000", cause); end
    rst = 1'b0; tick();
    chk_cnt++; if (hold !== 2'b01) begin err_cnt++; $display("FAIL rm_rehold: got %b want 01", hold); end
    tick();
    chk_cnt++; if (halted !== 2'b01) begin err_cnt++; $display("FAIL rm_rehalt: got %b want 01", halted); end
    chk_cnt++; if (cause !== 4'b0001) begin err_cnt++; $display("FAIL rm_recause: got %b want 0001", cause); end
    stall = 2'b00; tick(); tick();
  endtask

  initial begin
    rst = 1'b1; stall = '0; step_en = '0; hwbp_en = '0; retire = '0; idle = 2'b11;
    hwbp_addr = '0; pc = '0;
    test_reset();
    test_host_halt();
    test_hwbp();
    test_step();
    test_priority();
    test_drain_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/adbg_core_halt_ctrl.md
Name: adbg_core_halt_ctrl

Overview:
- CPU-side responder to the debug unit's per-core stall/breakpoint interface.
- Consumes the stall vector and produces the breakpoint vector.
- Per core:
  - freezes the pipeline and waits for drain;
  - reports halted state and halt cause;
  - implements single-step and one hardware PC breakpoint.
- Sits in the CPU clock domain between the debug status logic and the cores.

Parameters:
- NB_CORES, 4, number of cores served (one FSM per core).
- ADDR_W, 32, PC / breakpoint address width.
- DRAIN_TO, 255, maximum cycles to wait for core_idle_i in DRAIN; 8-bit counter, legal range 1..255.

Ports:
- cpu_clk_i  in  1  CPU clock; single clock for the whole block.
- cpu_rst_i  in  1  Reset; synchronous, active-high.
- cpu_stall_i  in  NB_CORES  Stall request from debug unit (level).
- step_en_i  in  NB_CORES  Single-step mode; sampled on HALTED->RESUME.
- hwbp_en_i  in  NB_CORES  Hardware breakpoint enable.
- hwbp_addr_i  in  NB_CORES*ADDR_W  Breakpoint PC; core i uses bits [i*ADDR_W +: ADDR_W].
- core_pc_i  in  NB_CORES*ADDR_W  PC of the retiring instruction; same slicing.
- core_retire_i  in  NB_CORES  One-cycle pulse per retired instruction.
- core_idle_i  in  NB_CORES  Pipeline empty, no outstanding bus access.
- core_hold_o  out  NB_CORES  Freeze fetch/issue.
- bp_o  out  NB_CORES  Breakpoint event; 1-cycle pulse.
- halted_o  out  NB_CORES  Core is halted.
- halt_cause_o  out  NB_CORES*2  Cause: 00 none, 01 host, 10 hwbp, 11 step.
- drain_err_o  out  NB_CORES  Sticky: drain timed out.

Behaviour:
- Reset values: all outputs registered and 0.
  - State RUN, cause 00, step_pend 0, stall_seen 0, counter 0.
  - Reset mid-halt returns to RUN the next cycle and releases hold.
- Per-core FSM states: RUN, DRAIN, HALTED, RESUME.
- RUN (hold 0). Events evaluated each cycle, in priority order:
  1. retire & hwbp_en & pc==hwbp_addr -> DRAIN, cause 10, bp_o pulse.
  2. retire & step_pend -> DRAIN, cause 11, bp_o pulse, step_pend cleared.
  3. cpu_stall_i -> DRAIN, cause 01, no bp_o.
  - Simultaneous events: highest priority wins; only one bp_o pulse.
- Latency:
  - Event at cycle n -> core_hold_o=1 and bp_o=1 at n+1.
  - bp_o is low at n+2.
- DRAIN (hold 1):
  - Counter increments each cycle.
  - core_idle_i -> HALTED, halted_o=1 the next cycle.
  - Counter reaches DRAIN_TO without idle -> HALTED anyway, drain_err_o set.
  - Retire pulses during DRAIN are ignored (no new bp_o, cause unchanged).
- HALTED (hold 1, halted_o 1):
  - stall_seen is set when cpu_stall_i==1.
  - Entry with cause 01 sets stall_seen immediately.
  - Exit to RESUME when stall_seen & !cpu_stall_i. This prevents a bp-caused halt from resuming before the debug stall propagates back.
- RESUME (one cycle):
  - hold 0, halted_o 0, cause <- 00.
  - step_pend <- step_en_i.
  - stall_seen and counter cleared.
  - Next state RUN.
  - If cpu_stall_i is asserted while in RESUME, it is taken from RUN on the following cycle.
- Step semantics: with step_en_i=1, exactly one instruction retires after resume, then a halt with cause 11.
- drain_err_o:
  - Sticky until reset or the next DRAIN entry.
  - Cleared on DRAIN entry, then possibly set again by that DRAIN.
- PC compare: full ADDR_W equality, unsigned; no masking.
- Cores are fully independent; no cross-core halt.

Decomposition:
- Shared package adbg_halt_pkg holds:
  - halt_state_t enum {RUN, DRAIN, HALTED, RESUME};
  - halt_cause_t 2-bit enum {CAUSE_NONE, CAUSE_HOST, CAUSE_HWBP, CAUSE_STEP}.
- Sub-module adbg_core_halt_fsm holds the single-core FSM, counter, cause, step and compare logic.
- The top instantiates adbg_core_halt_fsm NB_CORES times via generate and does vector slicing only.

Test Plan:
- Host halt, NB_CORES=2: cpu_stall_i=01 at cycle 10, core_idle_i[0]=1 at 14 -> core_hold_o[0]=1 at 11, halted_o[0]=1 at 15, cause0=01, bp_o=00 throughout, core 1 unaffected; stall drop -> RESUME, RUN, hold 0.
- HW breakpoint: hwbp_addr0=0x0000_1040, en=1, retire with pc 0x1040 -> bp_o[0] pulse exactly 1 cycle, cause 10; drop idle-wait; HALTED stays until cpu_stall_i rises and then falls.
- Single step: resume with step_en_i[0]=1 -> first retire (pc 0x1044) gives bp_o pulse, cause 11; second halt reached after exactly one retire.
- Priority: same cycle retire pc==hwbp_addr, step_pend=1, cpu_stall_i=1 -> cause 10, one bp_o pulse, step_pend cleared.
- Drain timeout: DRAIN_TO=4, core_idle_i held 0 -> HALTED after 4 DRAIN cycles, drain_err_o[0]=1, held across resume.
- Reset mid-operation: cpu_rst_i=1 while HALTED -> next cycle all outputs 0, state RUN; cpu_stall_i=1 after reset re-halts normally.
